// File: rtl/dp_pkg.sv
// Shared sizing helpers and FSM encoding for the dot-product feeder.
package dp_pkg;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  function automatic int dp_nbeats(input int pixel_n, input int parallel);
    return (pixel_n + parallel - 1) / parallel;
  endfunction

  // Wait long enough for the last beat to clear the multiplier and adder pipes.
  function automatic int dp_drain_cyc(input int fpm_delay, input int fpa_delay);
    return fpm_delay + fpa_delay + 4;
  endfunction

endpackage

// File: rtl/dp_line_buffer.sv
// Pixel image store: one write port, PARALLEL-wide registered read (1-cycle latency).
// Read lanes past the end of the image, and all lanes while rd_en is low, return zero.
module dp_line_buffer #(
  parameter int PIXEL_N    = 784,
  parameter int PARALLEL   = 2,
  parameter int PIXEL_SIZE = 10,
  parameter int BEAT_W     = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(PIXEL_N)-1:0]       wr_addr,
  input  logic [PIXEL_SIZE-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [BEAT_W-1:0]                rd_beat,
  output logic [PARALLEL*PIXEL_SIZE-1:0]   rd_data
);

  localparam int AW = $clog2(PIXEL_N);

  logic [PIXEL_SIZE-1:0] mem [PIXEL_N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar j = 0; j < PARALLEL; j++) begin : g_lane
    logic [31:0]           idx;
    logic [PIXEL_SIZE-1:0] lane_q;

    assign idx = 32'(rd_beat) * 32'(PARALLEL) + 32'(j);

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (rd_en && (idx < 32'(PIXEL_N))) begin
        lane_q <= mem[AW'(idx)];
      end else begin
        lane_q <= '0;
      end
    end

    assign rd_data[j*PIXEL_SIZE +: PIXEL_SIZE] = lane_q;
  end

endmodule

// File: rtl/dp_feeder.sv
// Buffers one image, streams it beat-by-beat with ROM weights to the dot-product stage,
// waits out its pipeline and holds the sum until result_ready (pixels stall in other states).
module dp_feeder
  import dp_pkg::*;
#(
  parameter int PIXEL_N     = 784,
  parameter int PARALLEL    = 2,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26,
  parameter int FPM_DELAY   = 6,
  parameter int FPA_DELAY   = 2
) (
  input  logic                                            clk,
  input  logic                                            GlobalReset,
  input  logic                                            pix_valid,
  input  logic [PIXEL_SIZE-1:0]                           pix_data,
  output logic                                            pix_ready,
  output logic [$clog2(dp_nbeats(PIXEL_N, PARALLEL))-1:0] w_addr,
  input  logic [PARALLEL*WEIGHT_SIZE-1:0]                 w_data,
  output logic [PARALLEL*PIXEL_SIZE-1:0]                  Pixels,
  output logic [PARALLEL*WEIGHT_SIZE-1:0]                 Weights,
  output logic                                            dp_rst,
  input  logic [VAL_SIZE-1:0]                             dp_value,
  output logic                                            result_valid,
  output logic [VAL_SIZE-1:0]                             result,
  input  logic                                            result_ready
);

  localparam int NBEATS    = dp_nbeats(PIXEL_N, PARALLEL);
  localparam int DRAIN_CYC = dp_drain_cyc(FPM_DELAY, FPA_DELAY);
  localparam int BW        = $clog2(NBEATS);
  localparam int CW        = $clog2(PIXEL_N);
  localparam int DW        = $clog2(DRAIN_CYC);

  state_t        state;
  logic [CW-1:0] pix_cnt;
  logic [DW-1:0] drain;
  logic          present;

  // w_addr doubles as the beat counter; it is parked at 0 outside STREAM.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state        <= S_LOAD;
      pix_cnt      <= '0;
      w_addr       <= '0;
      drain        <= '0;
      present      <= 1'b0;
      pix_ready    <= 1'b1;
      dp_rst       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      present <= (state == S_STREAM);
      case (state)
        S_LOAD: begin
          if (pix_valid && pix_ready) begin
            if (pix_cnt == CW'(PIXEL_N - 1)) begin
              pix_cnt   <= '0;
              pix_ready <= 1'b0;
              dp_rst    <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          dp_rst <= 1'b0;
          w_addr <= '0;
          state  <= S_STREAM;
        end
        S_STREAM: begin
          if (w_addr == BW'(NBEATS - 1)) begin
            w_addr <= '0;
            drain  <= '0;
            state  <= S_DRAIN;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // The first DRAIN cycle still presents the last beat; counting starts after it.
          if (!present) begin
            if (drain == DW'(DRAIN_CYC - 1)) begin
              drain        <= '0;
              result       <= dp_value;
              result_valid <= 1'b1;
              state        <= S_HOLD;
            end else begin
              drain <= drain + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            pix_ready    <= 1'b1;
            state        <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  dp_line_buffer #(
    .PIXEL_N    (PIXEL_N),
    .PARALLEL   (PARALLEL),
    .PIXEL_SIZE (PIXEL_SIZE),
    .BEAT_W     (BW)
  ) u_buf (
    .clk     (clk),
    .rst     (GlobalReset),
    .wr_en   (pix_valid && pix_ready),
    .wr_addr (pix_cnt),
    .wr_data (pix_data),
    .rd_en   (state == S_STREAM),
    .rd_beat (w_addr),
    .rd_data (Pixels)
  );

  assign Weights = present ? w_data : '0;

endmodule

// File: tb/tb_dp_feeder.sv
// Directed bench for dp_feeder: a 10-pixel instance for the main flow and a 9-pixel one for the ragged last beat.
module tb_dp_feeder;

  logic clk;
  logic GlobalReset;

  logic        pv, rr;
  logic [9:0]  pd;
  logic        pix_ready;
  logic [2:0]  w_addr;
  logic [37:0] w_data;
  logic [19:0] Pixels;
  logic [37:0] Weights;
  logic        dp_rst;
  logic [25:0] dp_value;
  logic        result_valid;
  logic [25:0] result;

  logic        pv9, rr9;
  logic [9:0]  pd9;
  logic        pix_ready9;
  logic [2:0]  w_addr9;
  logic [37:0] w_data9;
  logic [19:0] Pixels9;
  logic [37:0] Weights9;
  logic        dp_rst9;
  logic [25:0] dp_value9;
  logic        result_valid9;
  logic [25:0] result9;

  int passed = 0;
  int total  = 0;

  dp_feeder #(.PIXEL_N(10), .PARALLEL(2)) u_dut10 (
    .clk(clk), .GlobalReset(GlobalReset), .pix_valid(pv), .pix_data(pd), .pix_ready(pix_ready),
    .w_addr(w_addr), .w_data(w_data), .Pixels(Pixels), .Weights(Weights), .dp_rst(dp_rst),
    .dp_value(dp_value), .result_valid(result_valid), .result(result), .result_ready(rr)
  );

  dp_feeder #(.PIXEL_N(9), .PARALLEL(2)) u_dut9 (
    .clk(clk), .GlobalReset(GlobalReset), .pix_valid(pv9), .pix_data(pd9), .pix_ready(pix_ready9),
    .w_addr(w_addr9), .w_data(w_data9), .Pixels(Pixels9), .Weights(Weights9), .dp_rst(dp_rst9),
    .dp_value(dp_value9), .result_valid(result_valid9), .result(result9), .result_ready(rr9)
  );

  function automatic logic [37:0] rom(input int k);
    logic [18:0] hi, lo;
    hi = 19'(32'h501 + k * 16);
    lo = 19'(32'h300 + k * 16);
    return {hi, lo};
  endfunction

  function automatic logic [19:0] pk(input int hi, input int lo);
    logic [9:0] h, l;
    h = 10'(hi);
    l = 10'(lo);
    return {h, l};
  endfunction

  // Weight ROM with one cycle of read latency.
  always @(posedge clk) begin
    w_data  <= rom(int'(w_addr));
    w_data9 <= rom(int'(w_addr9));
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // Sends pixels base+1..base+10 back-to-back from LOAD, then checks CLEAR and all five beats.
  task automatic send_image10(input int base);
    chk("img_rdy_start", {63'd0, pix_ready}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      pv = 1'b1;
      pd = 10'(base + i + 1);
      @(negedge clk);
    end
    pv = 1'b0;
    chk("img_rdy_fall", {63'd0, pix_ready}, 64'd0);
    chk("img_dp_rst_hi", {63'd0, dp_rst}, 64'd1);
    @(negedge clk);
    chk("img_dp_rst_lo", {63'd0, dp_rst}, 64'd0);
    chk("img_waddr0", {61'd0, w_addr}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("img_waddr", {61'd0, w_addr}, (k < 4) ? 64'(k + 1) : 64'd0);
      chk("img_pixels", {44'd0, Pixels}, {44'd0, pk(base + 2*k + 2, base + 2*k + 1)});
      chk("img_weights", {26'd0, Weights}, {26'd0, rom(k)});
    end
    @(negedge clk);
    chk("img_pixels_after", {44'd0, Pixels}, 64'd0);
    chk("img_weights_after", {26'd0, Weights}, 64'd0);
  endtask

  typedef struct {
    logic        pv;
    logic [9:0]  pd;
    logic        e_rdy;
    logic        e_dprst;
    logic [2:0]  e_wa;
    logic [19:0] e_pix;
    logic [37:0] e_w;
  } vec_t;

  function automatic vec_t mk(input logic v, input int d, input logic r, input logic c,
                              input int wa, input logic [19:0] px, input logic [37:0] w);
    vec_t t;
    t.pv = v; t.pd = 10'(d); t.e_rdy = r; t.e_dprst = c;
    t.e_wa = 3'(wa); t.e_pix = px; t.e_w = w;
    return t;
  endfunction

  vec_t tbl [20];
  int   cnt_hi;
  int   bad;

  initial begin
    tbl[0]  = mk(1, 1,     1, 0, 0, 20'd0, 38'd0);
    tbl[1]  = mk(0, 10'h3ff, 1, 0, 0, 20'd0, 38'd0);
    tbl[2]  = mk(0, 10'h3ff, 1, 0, 0, 20'd0, 38'd0);
    tbl[3]  = mk(1, 2,     1, 0, 0, 20'd0, 38'd0);
    for (int i = 4; i < 12; i++) tbl[i] = mk(1, i - 1, 1, 0, 0, 20'd0, 38'd0);
    tbl[12] = mk(1, 10'h3ff, 0, 1, 0, 20'd0, 38'd0);
    tbl[13] = mk(0, 0, 0, 0, 0, 20'd0, 38'd0);
    tbl[14] = mk(0, 0, 0, 0, 1, pk(2, 1),  rom(0));
    tbl[15] = mk(0, 0, 0, 0, 2, pk(4, 3),  rom(1));
    tbl[16] = mk(0, 0, 0, 0, 3, pk(6, 5),  rom(2));
    tbl[17] = mk(0, 0, 0, 0, 4, pk(8, 7),  rom(3));
    tbl[18] = mk(0, 0, 0, 0, 0, pk(10, 9), rom(4));
    tbl[19] = mk(0, 0, 0, 0, 0, 20'd0, 38'd0);

    GlobalReset = 1'b1;
    pv = 1'b0; pd = '0; rr = 1'b0; dp_value = 26'h123;
    pv9 = 1'b0; pd9 = '0; rr9 = 1'b1; dp_value9 = 26'h0ab;
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", {63'd0, pix_ready}, 64'd1);
    chk("rst_result_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_result", {38'd0, result}, 64'd0);
    chk("rst_dp_rst", {63'd0, dp_rst}, 64'd0);
    chk("rst_w_addr", {61'd0, w_addr}, 64'd0);
    chk("rst_pixels", {44'd0, Pixels}, 64'd0);
    chk("rst_weights", {26'd0, Weights}, 64'd0);
    GlobalReset = 1'b0;

    // Gapped load (1,0,0,1 then back-to-back) followed by the full stream.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) chk("pix_cnt_hold", {60'd0, u_dut10.pix_cnt}, 64'd1);
      if (i == 4) chk("pix_cnt_gap", {60'd0, u_dut10.pix_cnt}, 64'd2);
      chk("tbl_pix_ready", {63'd0, pix_ready}, {63'd0, tbl[i].e_rdy});
      chk("tbl_dp_rst", {63'd0, dp_rst}, {63'd0, tbl[i].e_dprst});
      chk("tbl_w_addr", {61'd0, w_addr}, {61'd0, tbl[i].e_wa});
      chk("tbl_pixels", {44'd0, Pixels}, {44'd0, tbl[i].e_pix});
      chk("tbl_weights", {26'd0, Weights}, {26'd0, tbl[i].e_w});
      pv = tbl[i].pv;
      pd = tbl[i].pd;
    end
    pv = 1'b0;

    // Last presentation was the row-18 cycle; result must appear 13 cycles after it.
    repeat (11) @(negedge clk);
    chk("drain_not_yet", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    chk("drain_valid", {63'd0, result_valid}, 64'd1);
    chk("drain_result", {38'd0, result}, 64'h123);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b1 || result !== 26'h123 || pix_ready !== 1'b0) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    rr = 1'b1;
    @(negedge clk);
    chk("hold_exit_valid", {63'd0, result_valid}, 64'd0);
    chk("hold_exit_ready", {63'd0, pix_ready}, 64'd1);

    // Back-to-back image with result_ready already high: one-cycle result_valid.
    send_image10(0);
    cnt_hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) cnt_hi++;
    end
    chk("valid_one_cycle", 64'(cnt_hi), 64'd1);
    chk("back_in_load", {63'd0, pix_ready}, 64'd1);

    // Reset during STREAM beat 2.
    for (int i = 0; i < 10; i++) begin
      pv = 1'b1;
      pd = 10'(100 + i);
      @(negedge clk);
    end
    pv = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_stream_beat2", {61'd0, w_addr}, 64'd2);
    GlobalReset = 1'b1;
    @(negedge clk);
    GlobalReset = 1'b0;
    chk("rst_mid_pixels", {44'd0, Pixels}, 64'd0);
    chk("rst_mid_weights", {26'd0, Weights}, 64'd0);
    chk("rst_mid_w_addr", {61'd0, w_addr}, 64'd0);
    chk("rst_mid_dp_rst", {63'd0, dp_rst}, 64'd0);
    chk("rst_mid_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, pix_ready}, 64'd1);

    // Partial image abandoned by reset, then a full one must line up from pixel 0.
    for (int i = 0; i < 3; i++) begin
      pv = 1'b1;
      pd = 10'(50 + i);
      @(negedge clk);
    end
    pv = 1'b0;
    GlobalReset = 1'b1;
    @(negedge clk);
    GlobalReset = 1'b0;
    chk("rst_load_cnt", {60'd0, u_dut10.pix_cnt}, 64'd0);
    send_image10(20);
    repeat (30) @(negedge clk);

    // Nine pixels over two lanes: the final beat carries one real pixel.
    for (int i = 0; i < 9; i++) begin
      pv9 = 1'b1;
      pd9 = 10'(i + 1);
      @(negedge clk);
    end
    pv9 = 1'b0;
    chk("p9_rdy_fall", {63'd0, pix_ready9}, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("p9_first_pixels", {44'd0, Pixels9}, {44'd0, pk(2, 1)});
      if (k == 4) begin
        chk("p9_last_pixels", {44'd0, Pixels9}, {44'd0, pk(0, 9)});
        chk("p9_last_weights", {26'd0, Weights9}, {26'd0, rom(4)});
      end
    end
    cnt_hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid9 === 1'b1 && result9 === 26'h0ab) cnt_hi++;
    end
    chk("p9_result", 64'(cnt_hi), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
